// File: rtl/inst_mem_slave.sv
// Instruction-side memory model for the core fetch port: preloadable word storage,
// fixed-latency in-order responses, bounded outstanding requests, optional grant stalls.
module inst_mem_slave #(
  parameter int unsigned MEM_WORDS       = 4096,
  parameter logic [31:0] BASE_ADDR       = 32'h8000_0000,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned GNT_STALL_EVERY = 0
) (
  input  logic        clk_i,
  input  logic        arst_ni,
  input  logic        inst_req_i,
  output logic        inst_grnt_o,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_data_o,
  output logic        inst_valid_o,
  output logic        inst_err_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned STL_W = (GNT_STALL_EVERY >= 2) ? $clog2(GNT_STALL_EVERY) : 1;
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(MEM_WORDS) * 33'd4;

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic [31:0]      r_mem [MEM_WORDS];
  rsp_t             r_pipe [LATENCY];
  logic [OUT_W-1:0] r_outst;

  logic             w_stall;
  logic             w_room;
  logic             w_accept;
  logic             w_rd_ok;
  logic             w_ld_ok;
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_ld_idx;
  rsp_t             w_rsp;

  function automatic logic addr_ok(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < END_ADDR) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    logic [31:0] w_off;
    w_off = a - BASE_ADDR;
    return IDX_W'(w_off >> 2);
  endfunction

  // Deterministic grant stall: one blocked cycle at the end of every period.
  generate
    if (GNT_STALL_EVERY >= 2) begin : g_stall
      logic [STL_W-1:0] r_stall_cnt;
      always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni)
          r_stall_cnt <= '0;
        else if (r_stall_cnt == STL_W'(GNT_STALL_EVERY - 1))
          r_stall_cnt <= '0;
        else
          r_stall_cnt <= r_stall_cnt + STL_W'(1);
      end
      assign w_stall = (r_stall_cnt == STL_W'(GNT_STALL_EVERY - 1));
    end else begin : g_no_stall
      assign w_stall = 1'b0;
    end
  endgenerate

  // A response leaving this cycle frees its slot for a same-cycle accept.
  assign w_room      = (32'(r_outst) - 32'(inst_valid_o)) < 32'(MAX_OUTSTANDING);
  assign inst_grnt_o = arst_ni & inst_req_i & ~load_we_i & ~w_stall & w_room;
  assign w_accept    = inst_grnt_o;

  assign w_rd_ok  = addr_ok(inst_addr_i);
  assign w_ld_ok  = addr_ok(load_addr_i);
  assign w_rd_idx = word_idx(inst_addr_i);
  assign w_ld_idx = word_idx(load_addr_i);

  always_comb begin
    w_rsp = '0;
    if (w_accept) begin
      w_rsp.vld  = 1'b1;
      w_rsp.err  = ~w_rd_ok;
      w_rsp.data = w_rd_ok ? r_mem[w_rd_idx] : 32'h0;
    end
  end

  // Storage is deliberately not reset so preloaded images survive a core reset.
  always_ff @(posedge clk_i) begin
    if (load_we_i && w_ld_ok)
      r_mem[w_ld_idx] <= load_data_i;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int unsigned i = 0; i < LATENCY; i++)
        r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_rsp;
      for (int unsigned i = 1; i < LATENCY; i++)
        r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni)
      r_outst <= '0;
    else if (w_accept && !inst_valid_o)
      r_outst <= r_outst + OUT_W'(1);
    else if (!w_accept && inst_valid_o)
      r_outst <= r_outst - OUT_W'(1);
  end

  // Idle pipeline stages carry zero data/err, so outputs are already qualified.
  assign inst_valid_o = r_pipe[LATENCY-1].vld;
  assign inst_err_o   = r_pipe[LATENCY-1].err;
  assign inst_data_o  = r_pipe[LATENCY-1].data;

endmodule

// File: tb/tb_inst_mem_slave.sv
// Self-checking bench: three instances (default, single-outstanding, stalled grant)
// checked every cycle against a behavioural scoreboard plus literal spot checks.
module tb_inst_mem_slave;

  localparam int LAT = 2;
  localparam logic [31:0] W0 = 32'hFCE0_8793;
  localparam logic [31:0] W1 = 32'h0000_0013;
  localparam logic [31:0] W2 = 32'h00A0_0093;
  localparam logic [31:0] W3 = 32'h0000_8067;
  localparam logic [31:0] WL = 32'hDEAD_BEEF;

  logic        clk;
  logic        arst_ni;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [31:0] laddr;
  logic [31:0] ldata;
  logic        gnt [3];
  logic        vld [3];
  logic        err [3];
  logic [31:0] dat [3];

  int n_cmp = 0;
  int n_fail = 0;

  inst_mem_slave #(.LATENCY(2), .MAX_OUTSTANDING(2), .GNT_STALL_EVERY(0)) u_dut0 (
    .clk_i(clk), .arst_ni(arst_ni), .inst_req_i(req), .inst_grnt_o(gnt[0]),
    .inst_addr_i(addr), .inst_data_o(dat[0]), .inst_valid_o(vld[0]), .inst_err_o(err[0]),
    .load_we_i(we), .load_addr_i(laddr), .load_data_i(ldata));
  inst_mem_slave #(.LATENCY(2), .MAX_OUTSTANDING(1), .GNT_STALL_EVERY(0)) u_dut1 (
    .clk_i(clk), .arst_ni(arst_ni), .inst_req_i(req), .inst_grnt_o(gnt[1]),
    .inst_addr_i(addr), .inst_data_o(dat[1]), .inst_valid_o(vld[1]), .inst_err_o(err[1]),
    .load_we_i(we), .load_addr_i(laddr), .load_data_i(ldata));
  inst_mem_slave #(.LATENCY(2), .MAX_OUTSTANDING(2), .GNT_STALL_EVERY(4)) u_dut2 (
    .clk_i(clk), .arst_ni(arst_ni), .inst_req_i(req), .inst_grnt_o(gnt[2]),
    .inst_addr_i(addr), .inst_data_o(dat[2]), .inst_valid_o(vld[2]), .inst_err_o(err[2]),
    .load_we_i(we), .load_addr_i(laddr), .load_data_i(ldata));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int maxp(input int k);
    return (k == 1) ? 1 : 2;
  endfunction

  function automatic int stl(input int k);
    return (k == 2) ? 4 : 0;
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= 32'h8000_0000) && (a < 32'h8000_4000) && (a[1:0] == 2'b00);
  endfunction

  // Scoreboard: responses scheduled by due cycle, memory keyed by byte address.
  logic [31:0] mem_m [logic [31:0]];
  bit          sv [3][8];
  bit          se [3][8];
  logic [31:0] sd [3][8];
  int          sph [3];
  int          mcyc = 0;

  always @(negedge clk) begin
    int slot;
    int nslot;
    int pend;
    bit stall;
    bit eg;
    if (!arst_ni) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rst_grnt%0d", k), 32'(gnt[k]), 32'h0);
        chk($sformatf("rst_valid%0d", k), 32'(vld[k]), 32'h0);
        chk($sformatf("rst_err%0d", k), 32'(err[k]), 32'h0);
        chk($sformatf("rst_data%0d", k), dat[k], 32'h0);
        for (int j = 0; j < 8; j++) begin
          sv[k][j] = 1'b0; se[k][j] = 1'b0; sd[k][j] = 32'h0;
        end
        sph[k] = 0;
      end
      mcyc = 0;
    end else begin
      slot  = mcyc % 8;
      nslot = (mcyc + LAT) % 8;
      for (int k = 0; k < 3; k++) begin
        pend = 0;
        for (int j = 0; j < 8; j++) pend += int'(sv[k][j]);
        stall = (stl(k) != 0) && (sph[k] == stl(k) - 1);
        eg = req && !we && !stall && ((pend - int'(sv[k][slot])) < maxp(k));
        chk($sformatf("grnt%0d", k), 32'(gnt[k]), 32'(eg));
        chk($sformatf("valid%0d", k), 32'(vld[k]), 32'(sv[k][slot]));
        chk($sformatf("err%0d", k), 32'(err[k]), 32'(se[k][slot]));
        chk($sformatf("data%0d", k), dat[k], sd[k][slot]);
        sv[k][slot] = 1'b0; se[k][slot] = 1'b0; sd[k][slot] = 32'h0;
        if (eg) begin
          sv[k][nslot] = 1'b1;
          se[k][nslot] = !in_rng(addr);
          sd[k][nslot] = (in_rng(addr) && mem_m.exists(addr)) ? mem_m[addr] : 32'h0;
        end
        if (stl(k) != 0) sph[k] = (sph[k] + 1) % stl(k);
      end
      if (we && in_rng(laddr)) mem_m[laddr] = ldata;
      mcyc++;
    end
  end

  logic [2:0]  s_g;
  logic [2:0]  s_v;
  logic        s_e0;
  logic [31:0] s_d0;

  // Called at posedge+1: drive, sample at negedge+1, return at next posedge+1.
  task automatic step(input logic r, input logic [31:0] a, input logic w,
                      input logic [31:0] la, input logic [31:0] ld);
    req = r; addr = a; we = w; laddr = la; ldata = ld;
    @(negedge clk); #1;
    s_g  = {gnt[2], gnt[1], gnt[0]};
    s_v  = {vld[2], vld[1], vld[0]};
    s_e0 = err[0];
    s_d0 = dat[0];
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic load(input logic [31:0] la, input logic [31:0] ld);
    step(1'b0, 32'h0, 1'b1, la, ld);
  endtask

  task automatic fetch1(input string nm, input logic [31:0] a, input logic e, input logic [31:0] d);
    step(1'b1, a, 1'b0, 32'h0, 32'h0);
    chk({nm, "_grnt_c0"}, 32'(s_g[0]), 32'h1);
    idle(1);
    chk({nm, "_valid_c1"}, 32'(s_v[0]), 32'h0);
    idle(1);
    chk({nm, "_valid_c2"}, 32'(s_v[0]), 32'h1);
    chk({nm, "_err_c2"}, 32'(s_e0), 32'(e));
    chk({nm, "_data_c2"}, s_d0, d);
    idle(2);
  endtask

  logic [11:0] gh0, gh1, gh2, v0;
  logic [31:0] d0 [12];
  int          nv;

  initial begin
    req = 0; addr = 0; we = 0; laddr = 0; ldata = 0;
    arst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1 arst_ni = 1'b1;

    load(32'h8000_0000, W0);
    // Load with a pending request: grant must stay low on every instance.
    step(1'b1, 32'h8000_0004, 1'b1, 32'h8000_0004, W1);
    chk("load_blocks_grnt", 32'(s_g), 32'h0);
    load(32'h8000_0008, W2);
    load(32'h8000_000C, W3);
    load(32'h8000_3FFC, WL);
    idle(2);

    fetch1("single", 32'h8000_0000, 1'b0, W0);
    fetch1("last_word", 32'h8000_3FFC, 1'b0, WL);
    fetch1("misaligned", 32'h8000_0002, 1'b1, 32'h0);
    fetch1("below_base", 32'h7FFF_FFFC, 1'b1, 32'h0);
    fetch1("past_end", 32'h8000_4000, 1'b1, 32'h0);

    // Throughput with held request and a changing address.
    for (int i = 0; i < 12; i++) begin
      step(i < 8, 32'h8000_0000 + 32'(4 * (i % 4)), 1'b0, 32'h0, 32'h0);
      gh0[i] = s_g[0]; gh1[i] = s_g[1]; gh2[i] = s_g[2]; v0[i] = s_v[0]; d0[i] = s_d0;
    end
    chk("tput_grnt_max2", 32'(gh0[7:0]), 32'h0000_00FF);
    chk("tput_grnt_max1", 32'(gh1[7:0]), 32'h0000_0055);
    chk("tput_stall_cnt", 32'($countones(gh2[7:0])), 32'd6);
    chk("tput_valid", 32'(v0), 32'h0000_03FC);
    chk("tput_d2", d0[2], W0);
    chk("tput_d3", d0[3], W1);
    chk("tput_d4", d0[4], W2);
    chk("tput_d5", d0[5], W3);
    chk("tput_d6", d0[6], W0);

    // Ignored preloads: out of range aliasing onto word 0, and misaligned.
    load(32'h9000_0000, 32'h1111_1111);
    load(32'h8000_0001, 32'h2222_2222);
    fetch1("bad_load_ignored", 32'h8000_0000, 1'b0, W0);

    // Mid-clock reset with a request held: outputs drop immediately.
    req = 1'b1; addr = 32'h8000_0004;
    #2 arst_ni = 1'b0;
    #1;
    chk("rst_async_grnt", 32'(gnt[0]), 32'h0);
    chk("rst_async_valid", 32'(vld[0]), 32'h0);
    @(posedge clk); #1 arst_ni = 1'b1;
    step(1'b1, 32'h8000_0004, 1'b0, 32'h0, 32'h0);
    chk("rst_release_grnt", 32'(s_g[0]), 32'h1);
    idle(3);

    // Reset while a response is in flight: it must never appear.
    step(1'b1, 32'h8000_0008, 1'b0, 32'h0, 32'h0);
    chk("flight_accept", 32'(s_g[0]), 32'h1);
    #1 arst_ni = 1'b0;
    idle(2);
    arst_ni = 1'b1;
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      nv += int'(s_v[0]) + int'(s_v[1]) + int'(s_v[2]);
    end
    chk("flight_dropped", 32'(nv), 32'h0);
    fetch1("mem_kept_after_rst", 32'h8000_000C, 1'b0, W3);

    // Long held request on the stalled instance: one low grant in every four.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0);
      gh2[i] = s_g[2];
    end
    chk("stall_every4", 32'($countones(gh2)), 32'd9);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
